// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared constants for the cpu_trace post-mortem trace buffer
//
// Holds the FSM state encoding and the bit layout of one trace entry.
// Entry layout (MSB..LSB): {stamp[STAMP_W], kill, push, pc_4a[32], st__to_push_5a[35]}.
// Everything below the stamp is fixed at 69 bits; the stamp width is a top-level parameter.

package cpu_trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRIG  = 2'd2;
  localparam logic [1:0] ST_DUMP  = 2'd3;

  localparam int DATA_LSB      = 0;
  localparam int DATA_W        = 35;
  localparam int PC_LSB        = DATA_LSB + DATA_W;
  localparam int PC_W          = 32;
  localparam int PUSH_BIT      = PC_LSB + PC_W;
  localparam int KILL_BIT      = PUSH_BIT + 1;
  localparam int STAMP_LSB     = KILL_BIT + 1;
  localparam int ENTRY_FIXED_W = STAMP_LSB;

  function automatic int entry_w(input int stamp_w);
    return stamp_w + ENTRY_FIXED_W;
  endfunction

endpackage

// File: rtl/cpu_trace_mem.sv
// rtl/cpu_trace_mem.sv - DEPTH x W trace storage, one sync write port, one comb read port
//
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data
// Storage is deliberately not reset: the owning FSM tracks which entries are valid.

module cpu_trace_mem #(
  parameter int ADDR_W = 4,
  parameter int W      = 85
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace.sv
// rtl/cpu_trace.sv - trigger-frozen circular trace of branch-resolve / stack-push events
//
// Ports:
//   clk, rst_b                      clock, synchronous active-high reset
//   kill_4a, pc_4a                  stage-4 branch/kill tap
//   st__push_5a, st__to_push_5a     stage-5 stack push tap
//   arm                             pulse: clear buffer and start capture
//   trig_en, trig_pc                PC-match trigger on a kill
//   rd_ready / rd_valid / rd_data   oldest-first drain port
//   state, count, wrapped           status

module cpu_trace
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST       = 4,
  parameter int STAMP_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    kill_4a,
  input  logic [31:0]             pc_4a,
  input  logic                    st__push_5a,
  input  logic [34:0]             st__to_push_5a,
  input  logic                    arm,
  input  logic                    trig_en,
  input  logic [31:0]             trig_pc,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [STAMP_W+68:0]     rd_data,
  output logic [1:0]              state,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    wrapped
);

  localparam int ENTRY_W = entry_w(STAMP_W);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] POST_V   = DEPTH_LOG2'(POST);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [1:0]            state_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic [STAMP_W-1:0]    stamp;
  logic                  wrapped_q;
  logic                  rd_valid_q;
  logic [ENTRY_W-1:0]    rd_data_q;

  logic                  evt;
  logic                  capturing;
  logic                  we;
  logic                  hit;
  logic [ENTRY_W-1:0]    wdata;
  logic [DEPTH_LOG2-1:0] start_ptr;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [ENTRY_W-1:0]    rdata;

  assign evt       = kill_4a | st__push_5a;
  // An arm pulse restarts the buffer, so the event in that cycle is dropped.
  assign capturing = ((state_q == ST_ARMED) || (state_q == ST_TRIG)) && !arm;
  assign we        = capturing && evt;
  assign hit       = trig_en && kill_4a && (pc_4a == trig_pc);
  assign wdata     = {stamp, kill_4a, st__push_5a, pc_4a, st__to_push_5a};

  // Once wrapped, the slot about to be written next is the oldest survivor.
  assign start_ptr = wrapped_q ? wr_ptr : '0;
  // First DUMP cycle (rd_valid still low) fetches the oldest entry; afterwards rd_ptr
  // always points at the entry to present after the current one is accepted.
  assign raddr     = rd_valid_q ? rd_ptr : start_ptr;

  cpu_trace_mem #(
    .ADDR_W (DEPTH_LOG2),
    .W      (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      post_cnt   <= '0;
      stamp      <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      stamp <= stamp + 1'b1;

      if (we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (count_q == CNT_FULL) begin
          wrapped_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_ONE;
        end
      end

      case (state_q)
        ST_IDLE, ST_ARMED, ST_TRIG: begin
          if (arm) begin
            state_q   <= ST_ARMED;
            wr_ptr    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
          end else if ((state_q == ST_ARMED) && we && hit) begin
            post_cnt <= POST_V;
            state_q  <= (POST > 0) ? ST_TRIG : ST_DUMP;
          end else if ((state_q == ST_TRIG) && we) begin
            // Later trigger matches in TRIG are just ordinary events here.
            post_cnt <= post_cnt - PTR_ONE;
            if (post_cnt == PTR_ONE) begin
              state_q <= ST_DUMP;
            end
          end
        end
        default: begin
          if (!rd_valid_q) begin
            rd_data_q  <= rdata;
            rd_valid_q <= 1'b1;
            rd_ptr     <= start_ptr + PTR_ONE;
          end else if (rd_ready) begin
            if (count_q == CNT_ONE) begin
              rd_valid_q <= 1'b0;
              count_q    <= '0;
              state_q    <= ST_IDLE;
            end else begin
              count_q   <= count_q - CNT_ONE;
              rd_data_q <= rdata;
              rd_ptr    <= rd_ptr + PTR_ONE;
            end
          end
        end
      endcase
    end
  end

  assign state    = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cpu_trace.sv
// tb/tb_cpu_trace.sv - directed self-checking bench for cpu_trace (POST=4 and POST=0 instances)

module tb_cpu_trace;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        kill = 1'b0;
  logic [31:0] pc = '0;
  logic        push = 1'b0;
  logic [34:0] pdata = '0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b1;
  logic [31:0] trig_pc = 32'h100;
  logic        rd_ready = 1'b0;
  logic        sel = 1'b0;

  logic        rv4, rv0;
  logic [84:0] rdat4, rdat0;
  logic [1:0]  st4, st0;
  logic [4:0]  cnt4, cnt0;
  logic        wr4, wr0;

  logic        rv;
  logic [84:0] rdat;
  logic [1:0]  st;
  logic [4:0]  cnt;
  logic        wrp;

  assign rv   = sel ? rv0   : rv4;
  assign rdat = sel ? rdat0 : rdat4;
  assign st   = sel ? st0   : st4;
  assign cnt  = sel ? cnt0  : cnt4;
  assign wrp  = sel ? wr0   : wr4;

  cpu_trace #(.DEPTH_LOG2(4), .POST(4), .STAMP_W(16)) dut4 (
    .clk(clk), .rst_b(rst_b), .kill_4a(kill), .pc_4a(pc), .st__push_5a(push),
    .st__to_push_5a(pdata), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_ready(rd_ready), .rd_valid(rv4), .rd_data(rdat4), .state(st4),
    .count(cnt4), .wrapped(wr4)
  );

  cpu_trace #(.DEPTH_LOG2(4), .POST(0), .STAMP_W(16)) dut0 (
    .clk(clk), .rst_b(rst_b), .kill_4a(kill), .pc_4a(pc), .st__push_5a(push),
    .st__to_push_5a(pdata), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_ready(rd_ready), .rd_valid(rv0), .rd_data(rdat0), .state(st0),
    .count(cnt0), .wrapped(wr0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [84:0] got [0:31];
  logic [84:0] expv [0:31];
  int got_n;
  bit pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [84:0] mk(input int s, input bit k, input bit p,
                                     input logic [31:0] epc, input logic [34:0] d);
    logic [15:0] s16;
    s16 = s[15:0];
    return {s16, k, p, epc, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    cyc();
    rst_b = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic ev(input bit k, input bit p, input logic [31:0] epc, input logic [34:0] d);
    kill = k; push = p; pc = epc; pdata = d;
    cyc();
    kill = 1'b0; push = 1'b0; pc = '0; pdata = '0;
  endtask

  // arm (right after reset: stamps start at 1), 3 pushes, trigger kill, 4 pushes
  task automatic scenario(input logic [34:0] base);
    do_arm();
    for (int i = 0; i < 3; i++) ev(1'b0, 1'b1, 32'h0, base + 35'(i));
    ev(1'b1, 1'b0, 32'h100, 35'h0);
    for (int i = 3; i < 7; i++) ev(1'b0, 1'b1, 32'h0, base + 35'(i));
    for (int j = 0; j < 8; j++) begin
      if (j < 3)       expv[j] = mk(j + 1, 1'b0, 1'b1, 32'h0, base + 35'(j));
      else if (j == 3) expv[j] = mk(4, 1'b1, 1'b0, 32'h100, 35'h0);
      else             expv[j] = mk(j + 1, 1'b0, 1'b1, 32'h0, base + 35'(j - 1));
    end
  endtask

  task automatic drain(input int n, input bit bp);
    int budget;
    int pi;
    bit stalled;
    logic [84:0] prev;
    got_n = 0; budget = 0; pi = 0; stalled = 1'b0; prev = '0;
    while (got_n < n && budget < 300) begin
      if (rv) begin
        if (stalled) chk("stall_hold", rdat, prev);
        rd_ready = bp ? pat[pi % 6] : 1'b1;
        pi++;
        if (rd_ready) begin
          got[got_n] = rdat;
          got_n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = rdat;
        end
      end else begin
        if (stalled) chk("stall_valid", rv, 1'b1);
        rd_ready = 1'b0;
      end
      cyc();
      budget++;
    end
    rd_ready = 1'b0;
    chk("drain_count", got_n, n);
  endtask

  initial begin
    #1;
    // reset state, then events without arm are ignored
    sel = 1'b0;
    do_reset();
    chk("rst_state", st, 2'd0);
    chk("rst_count", cnt, 5'd0);
    chk("rst_valid", rv, 1'b0);
    chk("rst_data", rdat, 85'h0);
    chk("rst_wrapped", wrp, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ev(1'b0, 1'b1, 32'h0, 35'(i));
      chk("noarm_state", st, 2'd0);
      chk("noarm_count", cnt, 5'd0);
      chk("noarm_valid", rv, 1'b0);
    end

    // basic capture with POST=4
    do_reset();
    scenario(35'h1);
    chk("basic_state_dump", st, 2'd3);
    chk("basic_count", cnt, 5'd8);
    chk("basic_wrapped", wrp, 1'b0);
    drain(8, 1'b0);
    for (int j = 0; j < 8; j++) chk($sformatf("basic_entry%0d", j), got[j], expv[j]);
    chk("basic_end_state", st, 2'd0);
    chk("basic_end_valid", rv, 1'b0);
    chk("basic_end_count", cnt, 5'd0);

    // wrap with POST=0
    sel = 1'b1;
    do_reset();
    do_arm();
    for (int i = 1; i <= 20; i++) ev(1'b0, 1'b1, 32'h0, 35'(i));
    ev(1'b1, 1'b0, 32'h100, 35'h0);
    chk("wrap_state_dump", st, 2'd3);
    chk("wrap_wrapped", wrp, 1'b1);
    chk("wrap_count", cnt, 5'd16);
    drain(16, 1'b0);
    for (int j = 0; j < 15; j++)
      chk($sformatf("wrap_entry%0d", j), got[j], mk(6 + j, 1'b0, 1'b1, 32'h0, 35'(6 + j)));
    chk("wrap_entry15", got[15], mk(21, 1'b1, 1'b0, 32'h100, 35'h0));
    chk("wrap_end_valid", rv, 1'b0);
    chk("wrap_end_state", st, 2'd0);

    // backpressure during drain
    sel = 1'b0;
    do_reset();
    scenario(35'h11);
    drain(8, 1'b1);
    for (int j = 0; j < 8; j++) chk($sformatf("bp_entry%0d", j), got[j], expv[j]);
    chk("bp_end_valid", rv, 1'b0);

    // simultaneous kill+push, trig_en gating, re-match ignored in TRIG
    do_reset();
    trig_en = 1'b0;
    do_arm();
    ev(1'b1, 1'b1, 32'h100, 35'h9);
    chk("trigen_off_state", st, 2'd1);
    trig_en = 1'b1;
    ev(1'b1, 1'b1, 32'h200, 35'h55);
    chk("nomatch_state", st, 2'd1);
    ev(1'b1, 1'b0, 32'h100, 35'h0);
    chk("trig_state", st, 2'd2);
    ev(1'b1, 1'b0, 32'h100, 35'h0);
    chk("rematch_state", st, 2'd2);
    for (int i = 0; i < 3; i++) ev(1'b0, 1'b1, 32'h0, 35'h60 + 35'(i));
    chk("post_done_state", st, 2'd3);
    chk("post_done_count", cnt, 5'd7);
    drain(7, 1'b0);
    chk("sim_entry0", got[0], mk(1, 1'b1, 1'b1, 32'h100, 35'h9));
    chk("sim_entry1", got[1], mk(2, 1'b1, 1'b1, 32'h200, 35'h55));
    chk("sim_entry2", got[2], mk(3, 1'b1, 1'b0, 32'h100, 35'h0));
    chk("sim_entry3", got[3], mk(4, 1'b1, 1'b0, 32'h100, 35'h0));
    for (int j = 4; j < 7; j++)
      chk($sformatf("sim_entry%0d", j), got[j], mk(j + 1, 1'b0, 1'b1, 32'h0, 35'h60 + 35'(j - 4)));

    // reset mid-drain after two transfers
    do_reset();
    scenario(35'h21);
    drain(2, 1'b0);
    chk("mid_valid_before", rv, 1'b1);
    do_reset();
    chk("midrst_valid", rv, 1'b0);
    chk("midrst_state", st, 2'd0);
    chk("midrst_count", cnt, 5'd0);
    chk("midrst_wrapped", wrp, 1'b0);
    scenario(35'h31);
    drain(8, 1'b0);
    chk("midrst_stamp_restart", got[0], mk(1, 1'b0, 1'b1, 32'h0, 35'h31));
    chk("midrst_trig_entry", got[3], mk(4, 1'b1, 1'b0, 32'h100, 35'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
